// File: rtl/qpix_capture_pkg.sv
// Shared types and constants for the QPix event capture block.
//   win_state_e  : window sequencer states
//   DEF_*        : default parameter values used by the top and the FIFO
//   fifo_ptr_w() : address width for a FIFO of a given depth
package qpix_capture_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        OPEN  = 2'd2,
        DONE  = 2'd3
    } win_state_e;

    localparam int DEF_N_CH       = 16;
    localparam int DEF_TS_W       = 32;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_WIN_W      = 16;

    // Address bits needed to index FIFO_DEPTH entries (at least 1).
    function automatic int fifo_ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/event_fifo.sv
// Single-channel timestamp FIFO.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write push_data_i (accepted when not full, or when full and a pop happens)
//   pop_i        : remove the head into rd_data_o (ignored when empty)
//   flush_i      : empty the FIFO; overrides push and pop in the same cycle
//   push_data_i  : timestamp to store
//   rd_data_o    : last popped entry (registered, holds between pops)
//   rd_valid_o   : one-cycle pulse when rd_data_o updates
//   full_o       : FIFO full
//   empty_o      : FIFO empty
module event_fifo
    import qpix_capture_pkg::*;
#(
    parameter int TS_W       = DEF_TS_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            flush_i,
    input  logic [TS_W-1:0] push_data_i,
    output logic [TS_W-1:0] rd_data_o,
    output logic            rd_valid_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int PTR_W = fifo_ptr_w(FIFO_DEPTH);

    logic [TS_W-1:0] mem_q [FIFO_DEPTH];
    // One extra wrap bit distinguishes full from empty when the indices match.
    logic [PTR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]  rd_ptr_q, rd_ptr_d;
    logic [TS_W-1:0] rd_data_q, rd_data_d;
    logic            rd_valid_q;
    logic            do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q == {~rd_ptr_q[PTR_W], rd_ptr_q[PTR_W-1:0]});

    // A pop on a full FIFO frees the slot the push lands in; the read of the
    // old head and the write of the new entry use the same index in one edge.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            if (do_pop) begin
                rd_ptr_d  = rd_ptr_q + (PTR_W+1)'(1);
                rd_data_d = mem_q[rd_ptr_q[PTR_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= do_pop;
        end
    end

    // Storage is never reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/qpix_event_capture.sv
// Multi-channel hit timestamp capture with level trigger or delay/length window.
//   clk, rst_n          : clock, asynchronous active-low reset
//   trig_en             : level trigger, captures while high
//   win_start           : rising edge arms the window, zeroes ts, flushes FIFOs, clears ovf
//   win_delay, win_len  : window delay and open length in clk cycles
//   hits                : per-channel hit levels (synchronous)
//   rd_req              : per-channel read levels, each rising edge pops one entry
//   rd_data             : last popped timestamp, channel i at [i*TS_W +: TS_W]
//   rd_valid            : pulse when rd_data slice updates
//   empty, full, ovf    : per-channel FIFO status and sticky drop flag
//   win_active, win_done: window open level / close pulse
//   ts                  : free-running timestamp
module qpix_event_capture
    import qpix_capture_pkg::*;
#(
    parameter int N_CH       = DEF_N_CH,
    parameter int TS_W       = DEF_TS_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int WIN_W      = DEF_WIN_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trig_en,
    input  logic                 win_start,
    input  logic [WIN_W-1:0]     win_delay,
    input  logic [WIN_W-1:0]     win_len,
    input  logic [N_CH-1:0]      hits,
    input  logic [N_CH-1:0]      rd_req,
    output logic [N_CH*TS_W-1:0] rd_data,
    output logic [N_CH-1:0]      rd_valid,
    output logic [N_CH-1:0]      empty,
    output logic [N_CH-1:0]      full,
    output logic [N_CH-1:0]      ovf,
    output logic                 win_active,
    output logic                 win_done,
    output logic [TS_W-1:0]      ts
);

    logic             win_start_q;
    logic [N_CH-1:0]  hits_q, rd_req_q;
    logic             start_edge, cap_en;
    logic [N_CH-1:0]  hit_edge, rd_edge, push, pop_ok, drop;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [N_CH-1:0]  ovf_q, ovf_d;
    win_state_e       state_q;
    logic [WIN_W-1:0] cnt_q;
    logic             win_active_q, win_done_q;

    assign start_edge = win_start & ~win_start_q;
    assign hit_edge   = hits & ~hits_q;
    assign rd_edge    = rd_req & ~rd_req_q;
    assign cap_en     = trig_en | win_active_q;
    assign push       = hit_edge & {N_CH{cap_en}};
    assign pop_ok     = rd_edge & ~empty;
    // A hit is lost only when the FIFO stays full this cycle; a flush cycle discards it silently.
    assign drop       = push & full & ~pop_ok & {N_CH{~start_edge}};

    assign ts_d  = start_edge ? '0 : ts_q + TS_W'(1);
    assign ovf_d = start_edge ? '0 : (ovf_q | drop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_start_q <= 1'b0;
            hits_q      <= '0;
            rd_req_q    <= '0;
            ts_q        <= '0;
            ovf_q       <= '0;
        end else begin
            win_start_q <= win_start;
            hits_q      <= hits;
            rd_req_q    <= rd_req;
            ts_q        <= ts_d;
            ovf_q       <= ovf_d;
        end
    end

    // Window sequencer. win_active/win_done are registered so they line up
    // with the state they describe; OPEN is skipped when win_len is zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            win_active_q <= 1'b0;
            win_done_q   <= 1'b0;
        end else if (start_edge) begin
            state_q      <= DELAY;
            cnt_q        <= win_delay;
            win_active_q <= 1'b0;
            win_done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    win_active_q <= 1'b0;
                    win_done_q   <= 1'b0;
                end
                DELAY: begin
                    if (cnt_q == '0) begin
                        if (win_len == '0) begin
                            state_q    <= DONE;
                            win_done_q <= 1'b1;
                        end else begin
                            state_q      <= OPEN;
                            cnt_q        <= win_len;
                            win_active_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - WIN_W'(1);
                    end
                end
                OPEN: begin
                    if (cnt_q == WIN_W'(1)) begin
                        state_q      <= DONE;
                        win_active_q <= 1'b0;
                        win_done_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - WIN_W'(1);
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    win_done_q <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    win_active_q <= 1'b0;
                    win_done_q   <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        event_fifo #(
            .TS_W       (TS_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst_n       (rst_n),
            .push_i      (push[i]),
            .pop_i       (rd_edge[i]),
            .flush_i     (start_edge),
            .push_data_i (ts_q),
            .rd_data_o   (rd_data[i*TS_W +: TS_W]),
            .rd_valid_o  (rd_valid[i]),
            .full_o      (full[i]),
            .empty_o     (empty[i])
        );
    end

    assign ts         = ts_q;
    assign ovf        = ovf_q;
    assign win_active = win_active_q;
    assign win_done   = win_done_q;

endmodule

// File: tb/tb_qpix_event_capture.sv
module tb_qpix_event_capture;

    localparam int N_CH  = 16;
    localparam int TS_W  = 32;
    localparam int DEPTH = 4;
    localparam int WIN_W = 16;
    localparam int DW    = N_CH * TS_W;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 trig_en = 1'b0;
    logic                 win_start = 1'b0;
    logic [WIN_W-1:0]     win_delay = '0;
    logic [WIN_W-1:0]     win_len = '0;
    logic [N_CH-1:0]      hits = '0;
    logic [N_CH-1:0]      rd_req = '0;
    logic [N_CH*TS_W-1:0] rd_data;
    logic [N_CH-1:0]      rd_valid, empty, full, ovf;
    logic                 win_active, win_done;
    logic [TS_W-1:0]      ts;

    qpix_event_capture #(
        .N_CH(N_CH), .TS_W(TS_W), .FIFO_DEPTH(DEPTH), .WIN_W(WIN_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .trig_en(trig_en), .win_start(win_start),
        .win_delay(win_delay), .win_len(win_len), .hits(hits), .rd_req(rd_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full), .ovf(ovf),
        .win_active(win_active), .win_done(win_done), .ts(ts)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Each channel is a plain ordered list of timestamps; the window is
    // described by the cycle it was armed and its delay/length in cycles.
    logic [TS_W-1:0] m_ts;
    logic [TS_W-1:0] m_mem [N_CH][DEPTH];
    int              m_cnt [N_CH];
    logic [TS_W-1:0] m_rd  [N_CH];
    logic [N_CH-1:0] m_vld, m_ovf, m_prev_hits, m_prev_rd;
    logic            m_prev_start, m_armed, m_active, m_done;
    longint          m_cyc, m_A, m_d, m_l;

    task automatic m_reset();
        m_ts = '0; m_vld = '0; m_ovf = '0; m_prev_hits = '0; m_prev_rd = '0;
        m_prev_start = 1'b0; m_armed = 1'b0; m_active = 1'b0; m_done = 1'b0;
        m_cyc = 0; m_A = 0; m_d = 0; m_l = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_cnt[i] = 0;
            m_rd[i]  = '0;
        end
    endtask

    task automatic m_step();
        logic se, ce, he, re, done_was;
        se = win_start & ~m_prev_start;
        ce = trig_en | m_active;
        m_cyc++;
        for (int i = 0; i < N_CH; i++) begin
            he = hits[i] & ~m_prev_hits[i];
            re = rd_req[i] & ~m_prev_rd[i];
            m_vld[i] = 1'b0;
            if (se) begin
                m_cnt[i] = 0;
                m_ovf[i] = 1'b0;
            end else begin
                if (re && m_cnt[i] > 0) begin
                    m_rd[i] = m_mem[i][0];
                    for (int j = 0; j < DEPTH - 1; j++) m_mem[i][j] = m_mem[i][j+1];
                    m_cnt[i]--;
                    m_vld[i] = 1'b1;
                end
                if (he && ce) begin
                    if (m_cnt[i] == DEPTH) m_ovf[i] = 1'b1;
                    else begin
                        m_mem[i][m_cnt[i]] = m_ts;
                        m_cnt[i]++;
                    end
                end
            end
        end
        m_ts = se ? '0 : m_ts + TS_W'(1);
        done_was = m_done;
        if (se) begin
            m_armed = 1'b1;
            m_A = m_cyc;
            m_d = longint'(win_delay);
        end else if (done_was) begin
            m_armed = 1'b0;
        end
        m_active = 1'b0;
        m_done   = 1'b0;
        if (m_armed && !se) begin
            if (m_cyc == m_A + m_d + 1) m_l = longint'(win_len);
            if (m_cyc > m_A + m_d) begin
                if (m_l == 0) m_done = (m_cyc == m_A + m_d + 1);
                else begin
                    m_active = (m_cyc <= m_A + m_d + m_l);
                    m_done   = (m_cyc == m_A + m_d + m_l + 1);
                end
            end
        end
        m_prev_start = win_start;
        m_prev_hits  = hits;
        m_prev_rd    = rd_req;
    endtask

    task automatic m_check();
        logic [DW-1:0]   ev;
        logic [N_CH-1:0] ee, ef;
        for (int i = 0; i < N_CH; i++) begin
            ev[i*TS_W +: TS_W] = m_rd[i];
            ee[i] = (m_cnt[i] == 0);
            ef[i] = (m_cnt[i] == DEPTH);
        end
        chk("mdl_ts",       DW'(ts),         DW'(m_ts));
        chk("mdl_rd_data",  rd_data,         ev);
        chk("mdl_rd_valid", DW'(rd_valid),   DW'(m_vld));
        chk("mdl_empty",    DW'(empty),      DW'(ee));
        chk("mdl_full",     DW'(full),       DW'(ef));
        chk("mdl_ovf",      DW'(ovf),        DW'(m_ovf));
        chk("mdl_active",   DW'(win_active), DW'(m_active));
        chk("mdl_done",     DW'(win_done),   DW'(m_done));
    endtask

    always @(posedge clk) begin
        if (!rst_n) m_reset();
        else m_step();
        #1;
        m_check();
    end

    // ---------------- directed table ----------------
    typedef struct {
        logic        hit;
        logic        rd;
        logic        e_empty;
        logic        e_full;
        logic        e_ovf;
        logic        e_vld;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl [20];

    initial begin
        logic [19:0] c_hit, c_rd, c_empty, c_full, c_ovf, c_vld;
        int          c_data [20];
        logic [TS_W-1:0] exp_ts [N_CH];
        int first, act_cnt, done_cnt, done_at, n;

        // Row k is applied in the cycle where ts == k (first cycle after reset).
        c_hit   = 20'b0000000000_1010101010;
        c_rd    = 20'b1010101010_0000000000;
        c_empty = 20'b1110000000_0000000001;
        c_full  = 20'b0000000001_1110000000;
        c_ovf   = 20'b1111111111_1000000000;
        c_vld   = 20'b0010101010_0000000000;
        c_data  = '{0,0,0,0,0,0,0,0,0,0,0,1,1,3,3,5,5,7,7,7};
        for (int k = 0; k < 20; k++) begin
            tbl[k].hit     = c_hit[k];
            tbl[k].rd      = c_rd[k];
            tbl[k].e_empty = c_empty[k];
            tbl[k].e_full  = c_full[k];
            tbl[k].e_ovf   = c_ovf[k];
            tbl[k].e_vld   = c_vld[k];
            tbl[k].e_data  = c_data[k];
        end

        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        trig_en = 1'b1;
        for (int k = 0; k < 20; k++) begin
            hits[0]   = tbl[k].hit;
            rd_req[0] = tbl[k].rd;
            @(posedge clk); #2;
            chk($sformatf("tbl%0d_empty", k), DW'(empty[0]),    DW'(tbl[k].e_empty));
            chk($sformatf("tbl%0d_full", k),  DW'(full[0]),     DW'(tbl[k].e_full));
            chk($sformatf("tbl%0d_ovf", k),   DW'(ovf[0]),      DW'(tbl[k].e_ovf));
            chk($sformatf("tbl%0d_vld", k),   DW'(rd_valid[0]), DW'(tbl[k].e_vld));
            chk($sformatf("tbl%0d_data", k),  DW'(rd_data[TS_W-1:0]), DW'(tbl[k].e_data));
            @(negedge clk);
        end

        // Window: delay 100, length 250; hits before, inside and after on ch2.
        hits = '0; rd_req = '0; trig_en = 1'b0;
        win_delay = 16'd100; win_len = 16'd250; win_start = 1'b1;
        first = -1; act_cnt = 0; done_cnt = 0; done_at = -1;
        for (int c = 1; c <= 380; c++) begin
            @(negedge clk);
            win_start = 1'b0;
            hits[2] = (c == 30 || c == 200 || c == 370);
            @(posedge clk); #2;
            if (win_active) begin
                if (first < 0) first = c;
                act_cnt++;
            end
            if (win_done) begin
                done_cnt++;
                done_at = c;
            end
        end
        chk("win_rise",  DW'(first),    DW'(101));
        chk("win_len",   DW'(act_cnt),  DW'(250));
        chk("win_done_n", DW'(done_cnt), DW'(1));
        chk("win_done_at", DW'(done_at), DW'(351));
        @(negedge clk);
        hits[2] = 1'b0;
        rd_req[2] = 1'b1;
        @(posedge clk); #2;
        chk("win_hit_ts",  DW'(rd_data[2*TS_W +: TS_W]), DW'(199));
        chk("win_hit_vld", DW'(rd_valid[2]), DW'(1));
        chk("win_one_hit", DW'(empty[2]),    DW'(1));
        @(negedge clk);
        rd_req[2] = 1'b0;

        // Zero delay, zero length.
        win_delay = '0; win_len = '0; win_start = 1'b1;
        act_cnt = 0; done_cnt = 0; done_at = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            win_start = 1'b0;
            hits[3] = c[0];
            @(posedge clk); #2;
            if (win_active) act_cnt++;
            if (win_done) begin
                done_cnt++;
                done_at = c;
            end
        end
        chk("zero_active", DW'(act_cnt),  DW'(0));
        chk("zero_done_n", DW'(done_cnt), DW'(1));
        chk("zero_done_at", DW'(done_at), DW'(1));
        chk("zero_nocap",  DW'(empty[3]), DW'(1));
        @(negedge clk);
        hits[3] = 1'b0;

        // Staggered hits on channels 1..15 under the level trigger.
        @(negedge clk);
        trig_en = 1'b1;
        for (int i = 1; i < N_CH; i++) begin
            hits[i] = 1'b1;
            exp_ts[i] = m_ts;
            @(negedge clk);
        end
        hits = '0; trig_en = 1'b0;
        chk("stag_empty", DW'(empty), DW'(16'h0001));
        rd_req = 16'hFFFE;
        @(posedge clk); #2;
        for (int i = 1; i < N_CH; i++)
            chk($sformatf("stag_ts%0d", i), DW'(rd_data[i*TS_W +: TS_W]), DW'(exp_ts[i]));
        chk("stag_vld",   DW'(rd_valid), DW'(16'hFFFE));
        chk("stag_drain", DW'(empty),    DW'(16'hFFFF));
        @(negedge clk);
        rd_req = '0;

        // Restart during OPEN with a partly filled, overflowed ch0.
        @(negedge clk);
        win_delay = 16'd2; win_len = 16'd60; win_start = 1'b1;
        @(negedge clk);
        win_start = 1'b0;
        n = 0;
        while (!win_active && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rs_open", DW'(win_active), DW'(1));
        for (int j = 0; j < 5; j++) begin
            hits[0] = 1'b1;
            @(negedge clk);
            hits[0] = 1'b0;
            @(negedge clk);
        end
        for (int j = 0; j < 2; j++) begin
            rd_req[0] = 1'b1;
            @(negedge clk);
            rd_req[0] = 1'b0;
            @(negedge clk);
        end
        chk("rs_pre_ovf",   DW'(ovf[0]),   DW'(1));
        chk("rs_pre_empty", DW'(empty[0]), DW'(0));
        chk("rs_pre_full",  DW'(full[0]),  DW'(0));
        chk("rs_pre_open",  DW'(win_active), DW'(1));
        win_start = 1'b1;
        @(posedge clk); #2;
        chk("rs_flush",  DW'(empty[0]),   DW'(1));
        chk("rs_ovfclr", DW'(ovf[0]),     DW'(0));
        chk("rs_ts0",    DW'(ts),         DW'(0));
        chk("rs_closed", DW'(win_active), DW'(0));
        @(negedge clk);
        win_start = 1'b0;
        n = 0;
        while (!win_active && n < 20) begin
            @(posedge clk); #2;
            n++;
        end
        chk("rs_redelay", DW'(n), DW'(3));

        // Asynchronous reset in the middle of the window.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("ar_ts",     DW'(ts),         DW'(0));
        chk("ar_rdata",  rd_data,         DW'(0));
        chk("ar_rvld",   DW'(rd_valid),   DW'(0));
        chk("ar_empty",  DW'(empty),      DW'(16'hFFFF));
        chk("ar_full",   DW'(full),       DW'(0));
        chk("ar_ovf",    DW'(ovf),        DW'(0));
        chk("ar_active", DW'(win_active), DW'(0));
        chk("ar_done",   DW'(win_done),   DW'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic, checked every cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 99) < 3) trig_en = ~trig_en;
            hits      = N_CH'($urandom & $urandom);
            rd_req    = N_CH'($urandom & $urandom);
            win_start = ($urandom_range(0, 299) == 0);
            win_delay = WIN_W'($urandom_range(0, 15));
            win_len   = WIN_W'($urandom_range(0, 25));
        end
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qpix_event_capture.md
Name: qpix_event_capture

Overview:
Parametrised multi-channel event timestamp capture, the successor to the fixed 16-channel trigger/FIFO path in top_rtl. Each channel edge-detects its hit input and stores a free-running timestamp in a per-channel FIFO. Capture is enabled either by a level trigger or by a programmable delay/length window armed by a start pulse. Software pops entries through register-driven read levels.

Parameters:
N_CH, 16, number of hit channels.
TS_W, 32, timestamp width in bits.
FIFO_DEPTH, 4, entries per channel; power of 2, minimum 2.
WIN_W, 16, width of the window delay and length counters.

Ports:
clk  in  1  system clock (50 MHz).
rst_n  in  1  asynchronous active-low reset.
trig_en  in  1  level trigger; captures continuously while high.
win_start  in  1  rising edge arms a window, clears the timestamp, flushes all FIFOs and clears ovf.
win_delay  in  WIN_W  clk cycles from arm to window open.
win_len  in  WIN_W  clk cycles the window stays open.
hits  in  N_CH  per-channel hit levels, already synchronous to clk.
rd_req  in  N_CH  per-channel read level; each rising edge requests one pop.
rd_data  out  N_CH*TS_W  last popped timestamp per channel; channel i occupies bits [i*TS_W +: TS_W].
rd_valid  out  N_CH  one-cycle pulse when rd_data[i] updates.
empty  out  N_CH  FIFO empty flag per channel.
full  out  N_CH  FIFO full flag per channel.
ovf  out  N_CH  sticky flag per channel: a hit was dropped.
win_active  out  1  high while the window is open.
win_done  out  1  one-cycle pulse when the window closes.
ts  out  TS_W  current timestamp.

Behaviour:
- Reset values:
  - ts = 0, rd_data = 0, rd_valid = 0, ovf = 0, win_active = 0, win_done = 0.
  - empty = all 1s, full = 0, FSM in IDLE.
  - Edge-detect history registers reset to 0, so an input held high through reset is not an edge.
- Timestamp counter:
  - Increments by 1 every cycle and wraps modulo 2^TS_W.
  - Is set to 0 in the cycle after a win_start rising edge.
- Window FSM:
  - States: IDLE, DELAY, OPEN, DONE.
  - IDLE → DELAY on a win_start edge; the delay counter loads win_delay.
  - DELAY decrements; it moves to OPEN when the count is 0. With win_delay = 0, OPEN is entered on the next cycle.
  - OPEN loads win_len and stays for exactly win_len cycles with win_active = 1. With win_len = 0, it goes straight to DONE and win_active never asserts.
  - DONE pulses win_done for one cycle, then returns to IDLE.
  - A win_start edge in any non-IDLE state restarts at DELAY, with the same flush and clear as above.
  - win_delay and win_len are sampled only at load time.
- Capture enable = trig_en OR win_active.
- Write path:
  - A hits[i] rising edge while capture is enabled writes the current ts value into FIFO i.
  - The write takes effect on the next cycle; the stored value is the ts at the edge cycle.
  - If full[i] = 1 and no pop occurs in the same cycle, the hit is dropped and ovf[i] is set.
  - ovf is cleared only by reset or win_start.
- Read path:
  - A rd_req[i] rising edge with empty[i] = 0 pops the head. rd_data slice i updates and rd_valid[i] pulses one cycle later.
  - A rd_req[i] rising edge with empty[i] = 1 does nothing: no rd_valid, and rd_data holds its value.
- Simultaneous push and pop on one channel:
  - Both occur and occupancy is unchanged.
  - When full, the push is accepted because the pop frees a slot.
  - When empty, the pop is ignored and the push is accepted.
- Flush and capture ordering:
  - The flush on win_start takes priority over any push or pop in the same cycle.
  - A hit edge in that cycle is discarded.
- Channels are fully independent; there is no arbitration between them.

Decomposition:
- Package qpix_capture_pkg holds:
  - the window FSM state enum (IDLE, DELAY, OPEN, DONE);
  - the default parameter constants;
  - a clog2-based FIFO pointer width function.
- Sub-module event_fifo is a synchronous TS_W × FIFO_DEPTH FIFO with:
  - push, pop and flush inputs;
  - full, empty and registered head-data outputs;
  - push-while-full-with-pop handling as specified above.
  The top instantiates it N_CH times in a generate loop.

Test Plan:
- Reset, then trig_en = 1; pulse hits[0] at ts = 25 and ts = 50; pulse rd_req[0] three times → rd_data[0] = 25, then 50; rd_valid pulses twice; the third read gives no rd_valid and empty[0] stays 1.
- trig_en = 1; 5 hits on ch0 with FIFO_DEPTH = 4 → full[0] = 1 after 4 hits, ovf[0] = 1, and the 4 reads return the first 4 timestamps in order.
- trig_en = 0, win_delay = 100, win_len = 250, win_start edge → win_active rises 101 cycles after the edge and lasts 250 cycles, then win_done pulses once; hits before and after the window are not stored, hits inside are stored with ts relative to 0.
- win_delay = 0, win_len = 0, win_start edge → win_active never asserts, win_done pulses once, no hits are captured.
- trig_en = 1; hits[1..15] staggered by 1 cycle each → each FIFO holds exactly one entry with ts differing by 1; reads on each channel return the matching value and the other channels are unaffected.
- Restart: win_start during OPEN with 2 entries in ch0 and ovf[0] = 1 → the FIFO empties, ovf clears, ts resets to 0 and the window restarts at DELAY; rst_n asserted mid-window → all outputs return to their reset values immediately.
